// File: rtl/io_line_fill_dma.sv
// IO-mapped line fill engine: writes whole 4-word SDRAM lines with a constant
// or incrementing 16-bit pattern, then flags done and optionally interrupts.
module io_line_fill_dma #(
  parameter int ADDR_W          = 24,
  parameter int LINE_WORDS_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              wren,
  input  logic [2:0]        addr,
  input  logic [7:0]        from_cpu,
  output logic [7:0]        to_cpu,
  output logic              dma_int,
  output logic              mem_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [1:0]        mem_offset,
  input  logic              mem_ready,
  output logic [15:0]       to_mem
);

  localparam int LINE_WORDS = 1 << LINE_WORDS_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_NEXT, S_DONE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  start_addr;
  logic [ADDR_W-1:0]  work_addr;
  logic [7:0]         count;
  logic [7:0]         remaining;
  logic [15:0]        fill;
  logic [15:0]        word_cnt;
  logic               mode;
  logic               int_en;
  logic               done;
  logic               busy;
  logic [7:0]         rd_mux;
  logic               wr;
  logic               ctrl_wr;
  logic [15:0]        line_base;

  assign wr      = ce & wren;
  assign ctrl_wr = wr && (addr == 3'd6);

  assign mem_address = {work_addr[ADDR_W-1:LINE_WORDS_LOG2], {LINE_WORDS_LOG2{1'b0}}};
  assign dma_int     = done & int_en;

  // word_cnt advances per accepted beat; its line-aligned part is the
  // count of words in completed lines, mem_offset supplies the rest.
  assign line_base = {word_cnt[15:LINE_WORDS_LOG2], {LINE_WORDS_LOG2{1'b0}}};
  assign to_mem    = mode ? (fill + line_base + 16'(mem_offset)) : fill;

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      3'd0: rd_mux = start_addr[7:0];
      3'd1: rd_mux = start_addr[15:8];
      3'd2: rd_mux = start_addr[23:16];
      3'd3: rd_mux = count;
      3'd4: rd_mux = fill[7:0];
      3'd5: rd_mux = fill[15:8];
      3'd6: rd_mux = {5'b0, int_en, busy, done};
      3'd7: rd_mux = remaining;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      start_addr <= '0;
      work_addr  <= '0;
      count      <= 8'h00;
      remaining  <= 8'h00;
      fill       <= 16'h0000;
      word_cnt   <= 16'h0000;
      mode       <= 1'b0;
      int_en     <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_wren   <= 1'b0;
      to_cpu     <= 8'h00;
    end else begin
      to_cpu <= rd_mux;

      if (wr && !busy) begin
        case (addr)
          3'd0: start_addr[7:0]   <= from_cpu;
          3'd1: start_addr[15:8]  <= from_cpu;
          3'd2: start_addr[23:16] <= from_cpu;
          3'd3: count             <= from_cpu;
          3'd4: fill[7:0]         <= from_cpu;
          3'd5: fill[15:8]        <= from_cpu;
          default: ;
        endcase
      end

      if (ctrl_wr) begin
        int_en <= from_cpu[2];
        done   <= 1'b0;
        if (!busy) mode <= from_cpu[1];
      end

      case (state)
        S_IDLE: begin
          if (ctrl_wr && from_cpu[0]) begin
            if (count != 8'h00) begin
              work_addr <= start_addr;
              remaining <= count;
              word_cnt  <= 16'h0000;
              busy      <= 1'b1;
              mem_req   <= 1'b1;
              mem_wren  <= 1'b1;
              state     <= S_REQ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            word_cnt <= word_cnt + 16'd1;
            if (&mem_offset) begin
              mem_req  <= 1'b0;
              mem_wren <= 1'b0;
              state    <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          // Always one request-free cycle here so the controller can arbitrate.
          remaining <= remaining - 8'd1;
          work_addr <= work_addr + ADDR_W'(LINE_WORDS);
          if (remaining == 8'd1) begin
            state <= S_DONE;
          end else begin
            mem_req  <= 1'b1;
            mem_wren <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          if (!ctrl_wr) done <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
